// File: rtl/m_shiftctrl_pkg.sv
// Shared encodings for the serial shift controller.
// Op codes, FSM states and shift-counter mode pins.
package m_shiftctrl_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_RSV = 2'b10,
    SH_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // counter mode as {sa19,sa18}
  localparam logic [1:0] CNT_LOAD     = 2'b00;
  localparam logic [1:0] CNT_LOADBYTE = 2'b10;
  localparam logic [1:0] CNT_DEC      = 2'b01;
  localparam logic [1:0] CNT_HOLD     = 2'b11;

  function automatic logic [31:0] shift1(
    input logic [31:0] d,
    input logic        right,
    input logic        arith
  );
    if (right)
      return {arith & d[31], d[31:1]};
    else
      return {d[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/m_shiftctrl_dp.sv
// 32-bit operand register: load, or shift one bit left/right
// with optional sign fill.
module m_shiftctrl_dp
  import m_shiftctrl_pkg::*;
#(
  parameter bit HIGHLEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic        right,
  input  logic        arith,
  input  logic [31:0] a,
  output logic [31:0] data
);

  logic [31:0] d_nxt;

  generate
    if (HIGHLEVEL) begin : g_hl
      always_comb begin
        d_nxt = data;
        unique case (1'b1)
          load:    d_nxt = a;
          shift:   d_nxt = shift1(data, right, arith);
          default: d_nxt = data;
        endcase
      end
    end else begin : g_ll
      // flat AND-OR form, one 4-input function per bit
      logic [31:0] lvec;
      logic [31:0] rvec;
      logic        sh_l;
      logic        sh_r;
      logic        keep;
      assign lvec = {data[30:0], 1'b0};
      assign rvec = {arith & data[31], data[31:1]};
      assign sh_l = ~load & shift & ~right;
      assign sh_r = ~load & shift & right;
      assign keep = ~load & ~shift;
      assign d_nxt = ({32{load}} & a)
                   | ({32{sh_l}} & lvec)
                   | ({32{sh_r}} & rvec)
                   | ({32{keep}} & data);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data <= '0;
    else
      data <= d_nxt;
  end

endmodule

// File: rtl/m_shiftctrl.sv
// Serial shift controller: steers the external down-counter
// and shifts the operand until lastshift.
module m_shiftctrl
  import m_shiftctrl_pkg::*;
#(
  parameter bit HIGHLEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  op,
  input  logic        bytemode,
  input  logic [31:0] A,
  output logic        sa18,
  output logic        sa19,
  input  logic        lastshift,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result
);

  state_e      state_q;
  state_e      state_d;
  op_e         op_q;
  logic [1:0]  mode;
  logic        load;
  logic        shift;
  logic        right;
  logic        arith;
  logic [31:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= SH_SLL;
    end else begin
      state_q <= state_d;
      if (load)
        op_q <= op_e'(op);
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    mode      = CNT_HOLD;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // counter reloads every idle cycle
        req_ready = 1'b1;
        mode      = bytemode ? CNT_LOADBYTE : CNT_LOAD;
        if (req_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        mode = CNT_DEC;
        if (lastshift)
          state_d = ST_DONE;
        else
          shift = 1'b1;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        mode      = CNT_HOLD;
        if (res_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign right  = (op_q == SH_SRL) || (op_q == SH_SRA);
  assign arith  = (op_q == SH_SRA);
  assign sa19   = mode[1];
  assign sa18   = mode[0];
  assign result = data;

  m_shiftctrl_dp #(
    .HIGHLEVEL(HIGHLEVEL)
  ) u_dp (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(shift),
    .right(right),
    .arith(arith),
    .a    (A),
    .data (data)
  );

endmodule

// File: tb/tb_m_shiftctrl.sv
// Directed bench: both HIGHLEVEL builds side by side,
// each driving its own model of the 5-bit shift counter.
module tb_m_shiftctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  op;
  logic        bytemode;
  logic [31:0] A;
  logic [4:0]  B;
  logic        res_ready;

  logic        rq1, rq0, rv1, rv0;
  logic        s18_1, s19_1, s18_0, s19_0;
  logic        ls1, ls0;
  logic [31:0] r1, r0;
  logic [4:0]  cnt1, cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m_shiftctrl #(.HIGHLEVEL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rq1),
    .op(op), .bytemode(bytemode), .A(A),
    .sa18(s18_1), .sa19(s19_1), .lastshift(ls1),
    .res_valid(rv1), .res_ready(res_ready), .result(r1)
  );

  m_shiftctrl #(.HIGHLEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rq0),
    .op(op), .bytemode(bytemode), .A(A),
    .sa18(s18_0), .sa19(s19_0), .lastshift(ls0),
    .res_valid(rv0), .res_ready(res_ready), .result(r0)
  );

  // shift down-counter models (no reset, like the real counter)
  always_ff @(posedge clk) begin
    case ({s19_1, s18_1})
      2'b00: cnt1 <= B;
      2'b10: cnt1 <= {B[1:0], 3'b000};
      2'b01: if (cnt1 != 5'd0) cnt1 <= cnt1 - 5'd1;
      default: cnt1 <= cnt1;
    endcase
  end
  always_ff @(posedge clk) begin
    case ({s19_0, s18_0})
      2'b00: cnt0 <= B;
      2'b10: cnt0 <= {B[1:0], 3'b000};
      2'b01: if (cnt0 != 5'd0) cnt0 <= cnt0 - 5'd1;
      default: cnt0 <= cnt0;
    endcase
  end
  assign ls1 = ({s19_1, s18_1} == 2'b01) && (cnt1 == 5'd0);
  assign ls0 = ({s19_0, s18_0} == 2'b01) && (cnt0 == 5'd0);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_both(input string tag,
                          input logic [31:0] g1,
                          input logic [31:0] g0,
                          input logic [31:0] exp);
    chk({tag, "_hl1"}, g1, exp);
    chk({tag, "_hl0"}, g0, exp);
  endtask

  // inputs already set with req_valid=1, DUT idle
  task automatic accept_wait(input string tag,
                             input logic [31:0] exp_res,
                             input int exp_lat);
    int cyc;
    @(posedge clk);
    cyc = 1;
    #1;
    req_valid = 1'b0;
    chk_both({tag, "_busy"}, {31'd0, rq1}, {31'd0, rq0}, 32'd0);
    while (!rv1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk_both({tag, "_rv"}, {31'd0, rv1}, {31'd0, rv0}, 32'd1);
    chk_both({tag, "_res"}, r1, r0, exp_res);
  endtask

  task automatic drain(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk_both({tag, "_drain"}, {31'd0, rv1}, {31'd0, rv0}, 32'd0);
  endtask

  task automatic run(input string tag,
                     input logic [1:0] o,
                     input logic bm,
                     input logic [4:0] b,
                     input logic [31:0] a,
                     input logic [31:0] exp_res,
                     input int exp_lat);
    op = o;
    bytemode = bm;
    B = b;
    A = a;
    req_valid = 1'b1;
    accept_wait(tag, exp_res, exp_lat);
    drain(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    op = 2'b00;
    bytemode = 1'b0;
    A = '0;
    B = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_both("rst_ready", {31'd0, rq1}, {31'd0, rq0}, 32'd1);
    chk_both("rst_rv", {31'd0, rv1}, {31'd0, rv0}, 32'd0);
    chk_both("rst_res", r1, r0, 32'd0);
    chk_both("rst_sa", {30'd0, s19_1, s18_1},
             {30'd0, s19_0, s18_0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("sll5",   2'b00, 1'b0, 5'd5,  32'h0000_0001, 32'h0000_0020, 7);
    run("sra31",  2'b11, 1'b0, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    run("srl31",  2'b01, 1'b0, 5'd31, 32'h8000_0000, 32'h0000_0001, 33);
    run("srl0",   2'b01, 1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
    run("byte3",  2'b01, 1'b1, 5'd3,  32'hAABB_CCDD, 32'h0000_00AA, 26);
    run("byte1",  2'b00, 1'b1, 5'h1D, 32'h1234_5678, 32'h3456_7800, 10);
    run("rsv4",   2'b10, 1'b0, 5'd4,  32'h0000_000F, 32'h0000_00F0, 6);
    run("sra_pos",2'b11, 1'b0, 5'd3,  32'h4000_0010, 32'h0800_0002, 5);

    // back-pressure in DONE with a pending request
    op = 2'b00; bytemode = 1'b0; B = 5'd5; A = 32'h1;
    req_valid = 1'b1;
    accept_wait("stall", 32'h0000_0020, 7);
    op = 2'b01; B = 5'd4; A = 32'h0000_00F0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_both("stall_res", r1, r0, 32'h0000_0020);
      chk_both("stall_rv", {31'd0, rv1}, {31'd0, rv0}, 32'd1);
      chk_both("stall_sa", {30'd0, s19_1, s18_1},
               {30'd0, s19_0, s18_0}, 32'd3);
      chk_both("stall_rq", {31'd0, rq1}, {31'd0, rq0}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk_both("turn_rv", {31'd0, rv1}, {31'd0, rv0}, 32'd0);
    chk_both("turn_rq", {31'd0, rq1}, {31'd0, rq0}, 32'd1);
    accept_wait("turn", 32'h0000_000F, 6);
    drain("turn");

    // async reset three cycles into an N=20 shift
    op = 2'b00; bytemode = 1'b0; B = 5'd20; A = 32'h1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_both("mrst_rq", {31'd0, rq1}, {31'd0, rq0}, 32'd1);
    chk_both("mrst_rv", {31'd0, rv1}, {31'd0, rv0}, 32'd0);
    chk_both("mrst_res", r1, r0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post_rst", 2'b00, 1'b0, 5'd2, 32'h3, 32'h0000_000C, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
